uart_line_rx: RTL and testbench
===============================

# uart_line_rx

Receive-side line assembler that sits behind `uart_rx` on its `rx_data`/`rx_data_valid`/`rx_data_ready` handshake. It collects received bytes into an internal line buffer until a CR (0x0D) or LF (0x0A) terminator arrives. It then presents the completed line to a consumer through a random-access read port and holds it until the consumer acknowledges. It is the counterpart to the string-sending logic in the UART test top: that logic emits CR/LF-terminated text, and this block parses such text on the receive side.

## Interface
- `MAX_LEN`, default 32: line buffer depth in bytes; must be ≥2.
- `ADDR_W`, default `$clog2(MAX_LEN)`: read address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  active-low reset, asynchronous assert. One clock; reset is asynchronous and active-low.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_data_valid`  in  1  byte present on `rx_data`.
- `rx_data_ready`  out  1  block can accept a byte.
- `line_valid`  out  1  a completed line is held and readable.
- `line_len`  out  ADDR_W+1  byte count of the held line, 1..MAX_LEN; 0 when `line_valid`=0.
- `rd_addr`  in  ADDR_W  read index into the held line.
- `rd_data`  out  8  registered read data.
- `line_ack`  in  1  consumer releases the held line (single-cycle pulse).
- `overflow`  out  1  single-cycle pulse when a line exceeds `MAX_LEN`.
- `line_count`  out  16  number of completed lines delivered; wraps modulo 2^16.

## Operation
- A byte is accepted on a rising edge where `rx_data_valid` and `rx_data_ready` are both 1. No action occurs otherwise.
- `rx_data_ready` is a decode of the state: 1 in RECV and SKIP, 0 in HOLD.
- **State RECV** (reset state), with write pointer `wp` in 0..MAX_LEN:
  - Non-terminator byte with `wp`<MAX_LEN: write `mem[wp]` and increment `wp`.
  - Non-terminator byte with `wp`==MAX_LEN: pulse `overflow`, set `wp`=0, go to SKIP. The partial line is discarded.
  - Terminator with `wp`==0: empty line, ignored; stay in RECV. This makes CRLF, LFCR and blank lines harmless.
  - Terminator with `wp`>0: latch `line_len`=`wp`, set `wp`=0, go to HOLD.
- **State SKIP**: every non-terminator byte is discarded with no further `overflow` pulses. A terminator returns to RECV with no line delivered.
- **State HOLD**:
  - `line_valid`=1 and the buffer is frozen.
  - `line_ack`=1 sets `line_count`+=1, clears `line_len` to 0 and returns to RECV.
- `line_ack` in RECV or SKIP is ignored.
- Read port: `rd_data` ← `mem[rd_addr]` every cycle, in any state.
  - `rd_addr` ≥ `line_len` while in HOLD, or any read outside HOLD, returns undefined buffer contents. The exception is `rd_addr` ≥ MAX_LEN, which always returns 0x00.
- Terminator bytes are never stored.

## Timing
- Reset values:
  - `rx_data_ready`=1
  - `line_valid`=0
  - `line_len`=0
  - `rd_data`=0x00
  - `overflow`=0
  - `line_count`=0
  - state=RECV, `wp`=0
  - Buffer contents are not reset.
- Terminator accepted at edge N: `line_valid`=1 and `rx_data_ready`=0 from N+1.
- `line_ack` sampled high at edge M while `line_valid`=1: at M+1, `line_valid`=0, `rx_data_ready`=1, `line_len`=0 and `line_count` is incremented.
  - A byte cannot be accepted at edge M, because ready was 0.
- The first byte that can be accepted after an ack is at edge M+1.
- Read latency: `rd_addr` sampled at edge k gives `rd_data` valid after edge k, i.e. 1 cycle.
- `overflow` is high for exactly the one cycle following the offending byte's acceptance edge.
- Back-to-back bytes, one per cycle, are sustained in RECV and SKIP.
- Reset asserted mid-line or during HOLD: the block returns immediately to reset values and the held or partial line is lost.

## Test plan
- Send "AB",0x0D,0x0A → `line_valid`=1, `line_len`=2. `rd_addr`=0 gives `rd_data`=0x41 one cycle later; `rd_addr`=1 gives 0x42. After `line_ack`, the LF is absorbed with no second line and `line_count`=1.
- Send "X",0x0D then "Y",0x0D with upstream held valid and no ack → `rx_data_ready`=0 while "Y" waits and the line stays "X", `line_len`=1. After `line_ack`, "Y" is accepted in the cycle after ready rises; the next line has `line_len`=1, `rd_data`=0x59 and `line_count`=2.
- `MAX_LEN`=4: send "ABCDEF",0x0D → one `overflow` pulse, in the cycle after 'E' is accepted, and no `line_valid`. Then send "GH",0x0D → `line_len`=2 with data 0x47, 0x48.
- `MAX_LEN`=4: send "ABCD",0x0D → `line_len`=4, no `overflow`, and `rd_addr`=3 gives 0x44.
- Send "AB", pulse `rst_n` low, then send "C",0x0D → `line_len`=1, `rd_data`@0=0x43, `line_count`=1. Also pulse `line_ack` in RECV → no effect on `line_count` or state.

Source files
------------

// File: rtl/uart_line_rx.sv
// ---------------------------------------------------------------------------
// uart_line_rx
//
// Receive-side line assembler placed behind uart_rx. Incoming bytes are
// collected into a line buffer until a CR (0x0D) or LF (0x0A) arrives. The
// completed line is then held and can be read through a random-access,
// registered read port. It stays held until the consumer acknowledges it.
// Lines longer than MAX_LEN are dropped with a single overflow pulse. Empty
// lines, such as the second half of CRLF, are silently ignored.
//
// Parameters
//   MAX_LEN        line buffer depth in bytes (>= 2)
//   ADDR_W         read address width, $clog2(MAX_LEN)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx_data        byte from uart_rx
//   rx_data_valid  rx_data holds a byte
//   rx_data_ready  block can take a byte (low while a line is held)
//   line_valid     a completed line is held and readable
//   line_len       byte count of the held line, 0 when none is held
//   rd_addr        read index into the held line
//   rd_data        registered read data, one cycle after rd_addr
//   line_ack       consumer releases the held line (one-cycle pulse)
//   overflow       one-cycle pulse when a line exceeds MAX_LEN
//   line_count     number of lines delivered and acknowledged, mod 2^16
// ---------------------------------------------------------------------------
module uart_line_rx #(
   parameter int MAX_LEN = 32,
   parameter int ADDR_W  = $clog2(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_data_valid,
   output logic              rx_data_ready,
   output logic              line_valid,
   output logic [ADDR_W:0]   line_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   input  logic              line_ack,
   output logic              overflow,
   output logic [15:0]       line_count
);

   typedef enum logic [1:0] {
      ST_RECV = 2'd0,
      ST_SKIP = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W+1)'(MAX_LEN);
   localparam logic [ADDR_W:0] WP_ONE    = (ADDR_W+1)'(1);

   function automatic logic is_terminator(input logic [7:0] b);
      return (b == 8'h0D) || (b == 8'h0A);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W:0]     wp_q, wp_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [7:0]          rd_data_q, rd_data_d;

   logic [7:0]          mem_q [MAX_LEN];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [7:0]          mem_wd;

   logic                accept;
   logic                rd_in_range;

   assign rx_data_ready = (state_q != ST_HOLD);
   assign accept        = rx_data_valid && rx_data_ready;

   // Addresses at or beyond MAX_LEN only exist when MAX_LEN is not a power
   // of two; they read as zero instead of indexing past the buffer.
   if ((1 << ADDR_W) > MAX_LEN) begin : g_partial_range
      assign rd_in_range = ({1'b0, rd_addr} < MAX_LEN_W);
   end else begin : g_full_range
      assign rd_in_range = 1'b1;
   end

   // Next-state logic for the line FSM and its counters
   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      len_d   = len_q;
      ovf_d   = 1'b0;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      mem_wa  = wp_q[ADDR_W-1:0];
      mem_wd  = rx_data;

      case (state_q)
         ST_RECV: begin
            if (accept) begin
               if (is_terminator(rx_data)) begin
                  // A terminator with nothing buffered is the tail of a
                  // CRLF/LFCR pair or a blank line; drop it.
                  if (wp_q != '0) begin
                     len_d   = wp_q;
                     wp_d    = '0;
                     state_d = ST_HOLD;
                  end
               end else if (wp_q == MAX_LEN_W) begin
                  ovf_d   = 1'b1;
                  wp_d    = '0;
                  state_d = ST_SKIP;
               end else begin
                  mem_we = 1'b1;
                  wp_d   = wp_q + WP_ONE;
               end
            end
         end

         ST_SKIP: begin
            // Discard the rest of an over-long line up to its terminator.
            if (accept && is_terminator(rx_data)) begin
               state_d = ST_RECV;
            end
         end

         ST_HOLD: begin
            if (line_ack) begin
               cnt_d   = cnt_q + 16'd1;
               len_d   = '0;
               state_d = ST_RECV;
            end
         end

         default: begin
            state_d = ST_RECV;
            wp_d    = '0;
            len_d   = '0;
         end
      endcase
   end

   // The read port runs every cycle, regardless of state.
   always_comb begin
      rd_data_d = 8'h00;
      if (rd_in_range) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RECV;
         wp_q      <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= 16'd0;
         rd_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         wp_q      <= wp_d;
         len_q     <= len_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Line storage is not reset; stale bytes are harmless because only
   // indices below line_len are meaningful.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   assign line_valid = (state_q == ST_HOLD);
   assign line_len   = len_q;
   assign rd_data    = rd_data_q;
   assign overflow   = ovf_q;
   assign line_count = cnt_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_line_rx
//
// Self-checking bench for uart_line_rx. Two instances are used: one with the
// default 32-byte buffer and one with a 4-byte buffer. Both share the stimulus
// drivers, and sel routes valid/ack to one instance and its outputs back to
// the checks. Expected results come from the line-level rules. A line of
// 1..MAX bytes is delivered. A longer line produces one overflow and nothing
// else. Empty lines vanish. line_count moves only on an ack of a held line.
// ---------------------------------------------------------------------------
module tb_uart_line_rx;

   localparam int BIG   = 32;
   localparam int SMALL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        valid;
   logic [4:0]  rd_addr;
   logic        ack;
   logic        sel;

   logic        b_valid, b_ack, b_ready, b_lv, b_ovf;
   logic [5:0]  b_len;
   logic [7:0]  b_rd;
   logic [15:0] b_cnt;
   logic        s_valid, s_ack, s_ready, s_lv, s_ovf;
   logic [2:0]  s_len;
   logic [7:0]  s_rd;
   logic [15:0] s_cnt;

   logic        o_ready, o_lv, o_ovf;
   logic [5:0]  o_len;
   logic [7:0]  o_rd;
   logic [15:0] o_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt  [2];
   bit exp_hold [2];
   int ovf_seen [2];

   always #5 clk = ~clk;

   assign b_valid = valid && !sel;
   assign s_valid = valid &&  sel;
   assign b_ack   = ack && !sel;
   assign s_ack   = ack &&  sel;

   assign o_ready = sel ? s_ready : b_ready;
   assign o_lv    = sel ? s_lv    : b_lv;
   assign o_ovf   = sel ? s_ovf   : b_ovf;
   assign o_len   = sel ? {3'b000, s_len} : b_len;
   assign o_rd    = sel ? s_rd    : b_rd;
   assign o_cnt   = sel ? s_cnt   : b_cnt;

   uart_line_rx #(.MAX_LEN(BIG)) u_big (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(b_valid),
      .rx_data_ready(b_ready), .line_valid(b_lv), .line_len(b_len),
      .rd_addr(rd_addr), .rd_data(b_rd), .line_ack(b_ack),
      .overflow(b_ovf), .line_count(b_cnt)
   );

   uart_line_rx #(.MAX_LEN(SMALL)) u_small (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(s_valid),
      .rx_data_ready(s_ready), .line_valid(s_lv), .line_len(s_len),
      .rd_addr(rd_addr[1:0]), .rd_data(s_rd), .line_ack(s_ack),
      .overflow(s_ovf), .line_count(s_cnt)
   );

   // Overflow pulses are counted once per high cycle on each instance.
   always @(negedge clk) begin
      if (b_ovf === 1'b1) ovf_seen[0]++;
      if (s_ovf === 1'b1) ovf_seen[1]++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Offers one byte and returns #1 after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data = b;
      valid   = 1'b1;
      n       = 0;
      @(negedge clk);
      while (o_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout byte=%02h ready=%b required 1", b, o_ready);
         valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      if (exp_hold[sel]) begin
         exp_cnt[sel]++;
         exp_hold[sel] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; ack = 1'b0; rd_addr = '0; sel = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (b_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready_big got=%b exp=1", b_ready); end
      checks++; if (b_lv !== 1'b0)      begin errors++; $display("FAIL reset_lv_big got=%b exp=0", b_lv); end
      checks++; if (b_len !== 6'd0)     begin errors++; $display("FAIL reset_len_big got=%0d exp=0", b_len); end
      checks++; if (b_rd !== 8'h00)     begin errors++; $display("FAIL reset_rd_big got=%02h exp=00", b_rd); end
      checks++; if (b_ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf_big got=%b exp=0", b_ovf); end
      checks++; if (b_cnt !== 16'd0)    begin errors++; $display("FAIL reset_cnt_big got=%0d exp=0", b_cnt); end
      checks++; if (s_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready_small got=%b exp=1", s_ready); end
      checks++; if (s_lv !== 1'b0)      begin errors++; $display("FAIL reset_lv_small got=%b exp=0", s_lv); end
      checks++; if (s_len !== 3'd0)     begin errors++; $display("FAIL reset_len_small got=%0d exp=0", s_len); end
      checks++; if (s_rd !== 8'h00)     begin errors++; $display("FAIL reset_rd_small got=%02h exp=00", s_rd); end
      checks++; if (s_cnt !== 16'd0)    begin errors++; $display("FAIL reset_cnt_small got=%0d exp=0", s_cnt); end
      exp_cnt[0] = 0; exp_cnt[1] = 0; exp_hold[0] = 0; exp_hold[1] = 0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ab_crlf();
      sel = 1'b0;
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
      exp_hold[0] = 1'b1;
      checks++; if (o_lv !== 1'b1)      begin errors++; $display("FAIL ab_valid got=%b exp=1", o_lv); end
      checks++; if (o_len !== 6'd2)     begin errors++; $display("FAIL ab_len got=%0d exp=2", o_len); end
      checks++; if (o_ready !== 1'b0)   begin errors++; $display("FAIL ab_ready_hold got=%b exp=0", o_ready); end
      rd_addr = 5'd0; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h41)     begin errors++; $display("FAIL ab_rd0 got=%02h exp=41", o_rd); end
      rd_addr = 5'd1; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h42)     begin errors++; $display("FAIL ab_rd1 got=%02h exp=42", o_rd); end
      pulse_ack();
      checks++; if (o_lv !== 1'b0)      begin errors++; $display("FAIL ab_valid_after_ack got=%b exp=0", o_lv); end
      checks++; if (o_len !== 6'd0)     begin errors++; $display("FAIL ab_len_after_ack got=%0d exp=0", o_len); end
      checks++; if (o_ready !== 1'b1)   begin errors++; $display("FAIL ab_ready_after_ack got=%b exp=1", o_ready); end
      send_byte(8'h0A);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_lv !== 1'b0)      begin errors++; $display("FAIL ab_lf_absorbed got=%b exp=0", o_lv); end
      checks++; if (o_cnt !== 16'(exp_cnt[0])) begin errors++; $display("FAIL ab_count got=%0d exp=%0d", o_cnt, exp_cnt[0]); end
   endtask

   task automatic test_back_pressure();
      sel = 1'b0;
      send_byte(8'h58); send_byte(8'h0D);
      exp_hold[0] = 1'b1;
      rd_addr = 5'd0;
      rx_data = 8'h59;
      valid   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", i, o_ready); end
         checks++; if (o_len !== 6'd1)   begin errors++; $display("FAIL bp_len cyc=%0d got=%0d exp=1", i, o_len); end
      end
      checks++; if (o_rd !== 8'h58)      begin errors++; $display("FAIL bp_rd_x got=%02h exp=58", o_rd); end
      pulse_ack();
      checks++; if (o_ready !== 1'b1)    begin errors++; $display("FAIL bp_ready_after_ack got=%b exp=1", o_ready); end
      checks++; if (o_lv !== 1'b0)       begin errors++; $display("FAIL bp_valid_after_ack got=%b exp=0", o_lv); end
      checks++; if (o_cnt !== 16'(exp_cnt[0])) begin errors++; $display("FAIL bp_count_ack got=%0d exp=%0d", o_cnt, exp_cnt[0]); end
      // "Y" has been waiting on the bus and goes in at this edge.
      @(posedge clk); #1;
      valid = 1'b0;
      send_byte(8'h0D);
      exp_hold[0] = 1'b1;
      checks++; if (o_len !== 6'd1)      begin errors++; $display("FAIL bp_len_y got=%0d exp=1", o_len); end
      @(posedge clk); #1;
      checks++; if (o_rd !== 8'h59)      begin errors++; $display("FAIL bp_rd_y got=%02h exp=59", o_rd); end
      pulse_ack();
      checks++; if (o_cnt !== 16'(exp_cnt[0])) begin errors++; $display("FAIL bp_count_y got=%0d exp=%0d", o_cnt, exp_cnt[0]); end
   endtask

   task automatic test_overflow();
      int ovf0;
      sel  = 1'b1;
      ovf0 = ovf_seen[1];
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
      checks++; if (o_ovf !== 1'b0)      begin errors++; $display("FAIL ovf_early got=%b exp=0", o_ovf); end
      send_byte(8'h45);
      checks++; if (o_ovf !== 1'b1)      begin errors++; $display("FAIL ovf_pulse_after_e got=%b exp=1", o_ovf); end
      send_byte(8'h46);
      checks++; if (o_ovf !== 1'b0)      begin errors++; $display("FAIL ovf_single got=%b exp=0", o_ovf); end
      pulse_ack();
      send_byte(8'h0D);
      checks++; if (o_lv !== 1'b0)       begin errors++; $display("FAIL ovf_no_line got=%b exp=0", o_lv); end
      checks++; if (ovf_seen[1] - ovf0 != 1) begin errors++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_seen[1] - ovf0); end
      checks++; if (o_cnt !== 16'(exp_cnt[1])) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", o_cnt, exp_cnt[1]); end
      send_byte(8'h47); send_byte(8'h48); send_byte(8'h0D);
      exp_hold[1] = 1'b1;
      checks++; if (o_len !== 6'd2)      begin errors++; $display("FAIL gh_len got=%0d exp=2", o_len); end
      rd_addr = 5'd0; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h47)      begin errors++; $display("FAIL gh_rd0 got=%02h exp=47", o_rd); end
      rd_addr = 5'd1; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h48)      begin errors++; $display("FAIL gh_rd1 got=%02h exp=48", o_rd); end
      pulse_ack();
   endtask

   task automatic test_exact_fill();
      int ovf0;
      sel  = 1'b1;
      ovf0 = ovf_seen[1];
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44); send_byte(8'h0D);
      exp_hold[1] = 1'b1;
      checks++; if (o_lv !== 1'b1)       begin errors++; $display("FAIL full_valid got=%b exp=1", o_lv); end
      checks++; if (o_len !== 6'd4)      begin errors++; $display("FAIL full_len got=%0d exp=4", o_len); end
      checks++; if (ovf_seen[1] != ovf0) begin errors++; $display("FAIL full_no_ovf got=%0d exp=0", ovf_seen[1] - ovf0); end
      rd_addr = 5'd3; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h44)      begin errors++; $display("FAIL full_rd3 got=%02h exp=44", o_rd); end
      pulse_ack();
      checks++; if (o_cnt !== 16'(exp_cnt[1])) begin errors++; $display("FAIL full_count got=%0d exp=%0d", o_cnt, exp_cnt[1]); end
   endtask

   task automatic test_reset_midline();
      sel = 1'b0;
      send_byte(8'h41); send_byte(8'h42);
      rst_n = 1'b0;
      #2;
      checks++; if (o_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", o_ready); end
      checks++; if (o_cnt !== 16'd0)     begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", o_cnt); end
      checks++; if (o_rd !== 8'h00)      begin errors++; $display("FAIL mid_rst_rd got=%02h exp=00", o_rd); end
      exp_cnt[0] = 0; exp_cnt[1] = 0; exp_hold[0] = 0; exp_hold[1] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_byte(8'h43); send_byte(8'h0D);
      exp_hold[0] = 1'b1;
      checks++; if (o_len !== 6'd1)      begin errors++; $display("FAIL mid_len got=%0d exp=1", o_len); end
      rd_addr = 5'd0; @(posedge clk); #1;
      checks++; if (o_rd !== 8'h43)      begin errors++; $display("FAIL mid_rd0 got=%02h exp=43", o_rd); end
      pulse_ack();
      checks++; if (o_cnt !== 16'(exp_cnt[0])) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", o_cnt, exp_cnt[0]); end
      // An ack with no held line changes nothing.
      pulse_ack();
      checks++; if (o_cnt !== 16'(exp_cnt[0])) begin errors++; $display("FAIL recv_ack_count got=%0d exp=%0d", o_cnt, exp_cnt[0]); end
      checks++; if (o_ready !== 1'b1 || o_lv !== 1'b0) begin errors++; $display("FAIL recv_ack_state ready=%b lv=%b exp ready=1 lv=0", o_ready, o_lv); end
      send_byte(8'h51); send_byte(8'h0A);
      exp_hold[0] = 1'b1;
      checks++; if (o_len !== 6'd1)      begin errors++; $display("FAIL recv_ack_len got=%0d exp=1", o_len); end
      @(posedge clk); #1;
      checks++; if (o_rd !== 8'h51)      begin errors++; $display("FAIL recv_ack_rd got=%02h exp=51", o_rd); end
      pulse_ack();
   endtask

   task automatic test_random(input logic s);
      int m;
      int len;
      int ovf0;
      int gap;
      logic [7:0] q[$];
      logic [7:0] term;
      sel = s;
      m   = s ? SMALL : BIG;
      for (int ln = 0; ln < 10; ln++) begin
         len  = $urandom_range(0, m + 3);
         q    = {};
         for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(8'h20, 8'h7E)));
         term = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
         ovf0 = ovf_seen[s];
         for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            send_byte(q[i]);
            if (i == m) begin
               checks++;
               if (o_ovf !== 1'b1) begin errors++; $display("FAIL rnd_ovf sel=%0d line=%0d got=%b exp=1", s, ln, o_ovf); end
            end
         end
         send_byte(term);
         checks++;
         if (ovf_seen[s] - ovf0 != ((len > m) ? 1 : 0)) begin
            errors++; $display("FAIL rnd_ovf_count sel=%0d line=%0d len=%0d got=%0d exp=%0d", s, ln, len, ovf_seen[s] - ovf0, (len > m) ? 1 : 0);
         end
         if (len >= 1 && len <= m) begin
            exp_hold[s] = 1'b1;
            checks++; if (o_lv !== 1'b1)           begin errors++; $display("FAIL rnd_valid sel=%0d line=%0d got=%b exp=1", s, ln, o_lv); end
            checks++; if (o_len !== 6'(len))       begin errors++; $display("FAIL rnd_len sel=%0d line=%0d got=%0d exp=%0d", s, ln, o_len, len); end
            for (int i = 0; i < len; i++) begin
               rd_addr = 5'(i);
               @(posedge clk); #1;
               checks++; if (o_rd !== q[i])        begin errors++; $display("FAIL rnd_rd sel=%0d line=%0d addr=%0d got=%02h exp=%02h", s, ln, i, o_rd, q[i]); end
            end
            pulse_ack();
            checks++; if (o_cnt !== 16'(exp_cnt[s])) begin errors++; $display("FAIL rnd_count sel=%0d line=%0d got=%0d exp=%0d", s, ln, o_cnt, exp_cnt[s]); end
         end else begin
            checks++; if (o_lv !== 1'b0)           begin errors++; $display("FAIL rnd_no_line sel=%0d line=%0d len=%0d got=%b exp=0", s, ln, len, o_lv); end
         end
         // Optionally trail with the other half of a CRLF/LFCR pair.
         if ($urandom_range(0, 1) == 1) send_byte(term == 8'h0D ? 8'h0A : 8'h0D);
      end
      checks++; if (o_cnt !== 16'(exp_cnt[s])) begin errors++; $display("FAIL rnd_final_count sel=%0d got=%0d exp=%0d", s, o_cnt, exp_cnt[s]); end
   endtask

   initial begin
      test_reset();
      test_ab_crlf();
      test_back_pressure();
      test_overflow();
      test_exact_fill();
      test_reset_midline();
      test_random(1'b0);
      test_random(1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
